reg_write_decoder: RTL and testbench
====================================

// Module: reg_write_decoder
// PURPOSE
//  Write side of the 32x32 register bank. Accepts write requests, decodes the 5-bit address
//  to one-hot, and holds the 32 registers. Their contents drive reg0..reg31, which feed the
//  32:1 read mux.
//  Also provides a sequenced bank-clear (one register per cycle) with a valid/ready write handshake.
// PARAMETERS
//  DATA_W    32   register width; must equal 32 (matches read mux); byte lanes = DATA_W/8
//  ADDR_W    5    register address width; NUM_REGS = 2**ADDR_W = 32
//  ZERO_REG  1    1: reg0 hard-wired to 0, writes to it discarded; 0: reg0 writable
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  reset        in   1      asynchronous, active-high; clears all state
//  wr_valid     in   1      write request present
//  wr_ready     out  1      bank can accept a write this cycle
//  wr_addr      in   5      destination register
//  wr_data      in   32     write data
//  wr_be        in   4      byte enables, bit i -> wr_data[8i+7:8i]
//  wr_ack       out  1      1-cycle pulse the cycle after a write is accepted
//  clr_req      in   1      request sequenced clear of all registers
//  busy         out  1      clear sequence in progress
//  reg0..reg31  out  32 ea  current register contents (to read mux)
// BEHAVIOUR
//  Reset (async, any time incl. mid-clear):
//   - all regs = 0; state = IDLE; clear counter = 0
//   - wr_ack = 0; busy = 0; wr_ready = 1 (given clr_req = 0)
//  FSM states: IDLE, CLEAR.
//  - IDLE -> CLEAR on clr_req=1; clear counter loaded 0.
//  - CLEAR: each cycle reg[cnt] <= 0, cnt++; at cnt==31 clear reg31, go to IDLE
//    (exactly 32 CLEAR cycles). clr_req ignored while in CLEAR.
//  - busy = (state==CLEAR), registered.
//  wr_ready = (state==IDLE) && !clr_req (combinational); clear beats write on same cycle.
//  Accepted write = wr_valid && wr_ready at rising edge:
//  - bytes of reg[wr_addr] with wr_be[i]=1 take wr_data lanes; others hold.
//  - new value appears on regN output immediately after that edge (no write-through to current cycle).
//  - wr_ack = 1 for exactly the next cycle; back-to-back accepted writes give continuous wr_ack.
//  wr_be=0 or (ZERO_REG=1 && wr_addr=0): accepted and acked, no register changes.
//  wr_valid while wr_ready=0: not accepted, no ack; master must hold request until ready.
//  Only one register written per cycle; decoder one-hot gated by accept.
// STRUCTURE
//  Shared package: NUM_REGS, ADDR_W, DATA_W constants; state enum {IDLE, CLEAR}.
//  Sub-module dec5to32: combinational 5->32 one-hot decoder with enable input;
//   - instantiated once for write address (enable = accept)
//   - clear path indexes reg[cnt] directly
// TESTING
//  1 Reset: assert reset mid-run -> all reg0..31=0, busy=0, wr_ack=0, wr_ready=1 at once.
//  2 Write addr 5, data 0xDEADBEEF, be=4'hF -> reg5=0xDEADBEEF next cycle,
//    wr_ack one-cycle pulse, other regs unchanged.
//  3 Partial: reg7=0x11223344, write 0xAABBCCDD be=4'b0101 -> reg7=0x11BB33DD.
//  4 ZERO_REG=1, write 0xFFFFFFFF to addr 0 -> wr_ack pulses, reg0 stays 0.
//  5 Clear: fill regs with index values, pulse clr_req -> busy=1 for 32 cycles,
//    reg[k] zeroed on cycle k+1, wr_ready=0 throughout, held write accepted first cycle after.
//  6 clr_req and wr_valid same cycle -> write not accepted, no ack, clear starts;
//    reset at CLEAR cycle 10 -> IDLE, all regs 0.

Source files
------------

// File: rtl/reg_write_decoder_pkg.sv
// Shared definitions for the register-bank write side.
//   - bank geometry constants (data width, address width, register count)
//   - FSM state type (IDLE / CLEAR)
//   - be_merge: byte-lane merge of new write data into an existing word
package reg_write_decoder_pkg;

  localparam int unsigned BANK_DATA_W = 32;
  localparam int unsigned BANK_ADDR_W = 5;
  localparam int unsigned NUM_REGS    = 1 << BANK_ADDR_W;
  localparam int unsigned BANK_BE_W   = BANK_DATA_W / 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Lanes with be[i]=1 take new_v, all other lanes keep old_v.
  function automatic logic [BANK_DATA_W-1:0] be_merge(
    input logic [BANK_DATA_W-1:0] old_v,
    input logic [BANK_DATA_W-1:0] new_v,
    input logic [BANK_BE_W-1:0]   be
  );
    logic [BANK_DATA_W-1:0] res;
    res = old_v;
    for (int unsigned i = 0; i < BANK_BE_W; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_write_decoder_dec5to32.sv
// dec5to32: combinational 5-to-32 one-hot decoder with enable.
// Ports:
//   en      in   1   enable; when low the output is all zeros
//   addr    in   5   index to decode
//   onehot  out  32  bit [addr] set when en=1
module dec5to32 (
  input  logic        en,
  input  logic [4:0]  addr,
  output logic [31:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_write_decoder.sv
// reg_write_decoder: write side of the 32x32 register bank.
// Holds the 32 registers, accepts byte-enabled writes over a valid/ready
// handshake (acked one cycle later) and runs a sequenced bank clear that
// zeroes one register per cycle for 32 cycles.
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous active-high reset, clears all state
//   wr_valid     in   1   write request present
//   wr_ready     out  1   bank can accept a write this cycle
//   wr_addr      in   5   destination register
//   wr_data      in   32  write data
//   wr_be        in   4   byte enables, bit i -> wr_data[8i+7:8i]
//   wr_ack       out  1   pulse the cycle after each accepted write
//   clr_req      in   1   request sequenced clear of all registers
//   busy         out  1   clear sequence in progress
//   reg0..reg31  out  32  current register contents
module reg_write_decoder
  import reg_write_decoder_pkg::*;
#(
  parameter int unsigned DATA_W   = BANK_DATA_W,
  parameter int unsigned ADDR_W   = BANK_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic                wr_ack,
  input  logic                clr_req,
  output logic                busy,
  output logic [DATA_W-1:0]   reg0,
  output logic [DATA_W-1:0]   reg1,
  output logic [DATA_W-1:0]   reg2,
  output logic [DATA_W-1:0]   reg3,
  output logic [DATA_W-1:0]   reg4,
  output logic [DATA_W-1:0]   reg5,
  output logic [DATA_W-1:0]   reg6,
  output logic [DATA_W-1:0]   reg7,
  output logic [DATA_W-1:0]   reg8,
  output logic [DATA_W-1:0]   reg9,
  output logic [DATA_W-1:0]   reg10,
  output logic [DATA_W-1:0]   reg11,
  output logic [DATA_W-1:0]   reg12,
  output logic [DATA_W-1:0]   reg13,
  output logic [DATA_W-1:0]   reg14,
  output logic [DATA_W-1:0]   reg15,
  output logic [DATA_W-1:0]   reg16,
  output logic [DATA_W-1:0]   reg17,
  output logic [DATA_W-1:0]   reg18,
  output logic [DATA_W-1:0]   reg19,
  output logic [DATA_W-1:0]   reg20,
  output logic [DATA_W-1:0]   reg21,
  output logic [DATA_W-1:0]   reg22,
  output logic [DATA_W-1:0]   reg23,
  output logic [DATA_W-1:0]   reg24,
  output logic [DATA_W-1:0]   reg25,
  output logic [DATA_W-1:0]   reg26,
  output logic [DATA_W-1:0]   reg27,
  output logic [DATA_W-1:0]   reg28,
  output logic [DATA_W-1:0]   reg29,
  output logic [DATA_W-1:0]   reg30,
  output logic [DATA_W-1:0]   reg31
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic                accept;
  logic [NUM_REGS-1:0] wr_onehot;

  // A pending clear request blocks writes in the same cycle.
  assign wr_ready = (state_q == IDLE) && !clr_req;
  assign accept   = wr_valid && wr_ready;
  assign busy     = (state_q == CLEAR);

  dec5to32 u_wr_dec (
    .en     (accept),
    .addr   (wr_addr),
    .onehot (wr_onehot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_ack  <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      wr_ack <= accept;

      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Clear and write never coincide: writes are only accepted in IDLE.
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (state_q == CLEAR && cnt_q == ADDR_W'(i)) begin
          regs_q[i] <= '0;
        end else if (wr_onehot[i] && !(ZERO_REG != 0 && i == 0)) begin
          regs_q[i] <= be_merge(regs_q[i], wr_data, wr_be);
        end
      end
    end
  end

  assign reg0  = regs_q[0];
  assign reg1  = regs_q[1];
  assign reg2  = regs_q[2];
  assign reg3  = regs_q[3];
  assign reg4  = regs_q[4];
  assign reg5  = regs_q[5];
  assign reg6  = regs_q[6];
  assign reg7  = regs_q[7];
  assign reg8  = regs_q[8];
  assign reg9  = regs_q[9];
  assign reg10 = regs_q[10];
  assign reg11 = regs_q[11];
  assign reg12 = regs_q[12];
  assign reg13 = regs_q[13];
  assign reg14 = regs_q[14];
  assign reg15 = regs_q[15];
  assign reg16 = regs_q[16];
  assign reg17 = regs_q[17];
  assign reg18 = regs_q[18];
  assign reg19 = regs_q[19];
  assign reg20 = regs_q[20];
  assign reg21 = regs_q[21];
  assign reg22 = regs_q[22];
  assign reg23 = regs_q[23];
  assign reg24 = regs_q[24];
  assign reg25 = regs_q[25];
  assign reg26 = regs_q[26];
  assign reg27 = regs_q[27];
  assign reg28 = regs_q[28];
  assign reg29 = regs_q[29];
  assign reg30 = regs_q[30];
  assign reg31 = regs_q[31];

endmodule

// File: tb/tb_reg_write_decoder.sv
// Bench for reg_write_decoder: directed writes push their expected register
// value and full bank image into a queue; a negedge monitor pops one entry
// per wr_ack and compares. Reset/clear/handshake behaviour is checked inline.
module tb_reg_write_decoder;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_ack;
  logic        clr_req;
  logic        busy;
  logic [31:0] r [32];

  logic [31:0]   exp_regs [32];
  logic [1023:0] dut_bank;

  typedef struct packed {
    logic [4:0]    addr;
    logic [31:0]   val;
    logic [1023:0] bank;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  reg_write_decoder #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
    .clr_req(clr_req), .busy(busy),
    .reg0(r[0]),   .reg1(r[1]),   .reg2(r[2]),   .reg3(r[3]),
    .reg4(r[4]),   .reg5(r[5]),   .reg6(r[6]),   .reg7(r[7]),
    .reg8(r[8]),   .reg9(r[9]),   .reg10(r[10]), .reg11(r[11]),
    .reg12(r[12]), .reg13(r[13]), .reg14(r[14]), .reg15(r[15]),
    .reg16(r[16]), .reg17(r[17]), .reg18(r[18]), .reg19(r[19]),
    .reg20(r[20]), .reg21(r[21]), .reg22(r[22]), .reg23(r[23]),
    .reg24(r[24]), .reg25(r[25]), .reg26(r[26]), .reg27(r[27]),
    .reg28(r[28]), .reg29(r[29]), .reg30(r[30]), .reg31(r[31])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    dut_bank = '0;
    for (int i = 0; i < 32; i++) dut_bank[i*32 +: 32] = r[i];
  end

  function automatic logic [1023:0] pack_model();
    logic [1023:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) b[i*32 +: 32] = exp_regs[i];
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic check_bank(input string name, input logic [1023:0] act, input logic [1023:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 32; i++) check($sformatf("%s_reg%0d", tag, i), r[i], 32'h0);
    check({tag, "_busy"},     {31'h0, busy},     32'h0);
    check({tag, "_wr_ack"},   {31'h0, wr_ack},   32'h0);
    check({tag, "_wr_ready"}, {31'h0, wr_ready}, 32'h1);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
  endtask

  // Called at posedge+1 while idle; the write is accepted on the next edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic [31:0] expv);
    exp_t e;
    exp_regs[a] = expv;
    e.addr = a;
    e.val  = expv;
    e.bank = pack_model();
    sb_q.push_back(e);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = be;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  // Monitor: every ack must match the oldest outstanding write.
  always @(negedge clk) begin
    exp_t m;
    if (!reset && wr_ack) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: got wr_ack=1 expected no outstanding write");
      end else begin
        m = sb_q.pop_front();
        check($sformatf("ack_reg%0d", m.addr), r[m.addr], m.val);
        check_bank("ack_bank", dut_bank, m.bank);
      end
    end
  end

  initial begin
    exp_t h;
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; clr_req = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("init");
    reset = 1'b0;

    // Full write, then confirm the ack is a single pulse.
    @(posedge clk); #1;
    do_write(5'd5, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
    @(posedge clk); @(negedge clk);
    check("ack_single_pulse", {31'h0, wr_ack}, 32'h0);

    // Back-to-back writes: partial merge, no enables, upper-byte only, reg0.
    @(posedge clk); #1;
    do_write(5'd7, 32'h11223344, 4'hF,    32'h11223344);
    do_write(5'd7, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD);
    do_write(5'd3, 32'h12345678, 4'b0000, 32'h00000000);
    do_write(5'd5, 32'h000000FF, 4'b1000, 32'h00ADBEEF);
    do_write(5'd0, 32'hFFFFFFFF, 4'hF,    32'h00000000);
    @(posedge clk); @(posedge clk);

    // Asynchronous reset mid-run with non-zero contents.
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("midrun_rst");
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;

    // Fill registers with their index values.
    @(posedge clk); #1;
    for (int i = 1; i < 32; i++) do_write(i[4:0], i, 4'hF, i);
    @(posedge clk); @(posedge clk); #1;

    // Sequenced clear with a write held pending throughout.
    clr_req = 1'b1;
    #1;
    check("ready_low_on_clr", {31'h0, wr_ready}, 32'h0);
    @(posedge clk); #1;
    clr_req = 1'b0;
    model_clear();
    exp_regs[9] = 32'hCAFEF00D;
    h.addr = 5'd9; h.val = 32'hCAFEF00D; h.bank = pack_model();
    sb_q.push_back(h);
    wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      check($sformatf("clr%0d_busy", j),  {31'h0, busy},     32'h1);
      check($sformatf("clr%0d_ready", j), {31'h0, wr_ready}, 32'h0);
      check($sformatf("clr%0d_ack", j),   {31'h0, wr_ack},   32'h0);
      check($sformatf("clr%0d_reg%0d_held", j, j), r[j], j);
      if (j > 0) check($sformatf("clr%0d_reg%0d_zero", j, j - 1), r[j-1], 32'h0);
      @(posedge clk);
    end
    @(negedge clk);
    check("clr_done_busy",  {31'h0, busy},     32'h0);
    check("clr_done_ready", {31'h0, wr_ready}, 32'h1);
    check("clr_done_reg31", r[31], 32'h0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    // Clear and write in the same cycle: clear wins, then reset mid-clear.
    clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 32'h0BADF00D; wr_be = 4'hF;
    #1;
    check("collide_ready", {31'h0, wr_ready}, 32'h0);
    @(posedge clk); #1;
    clr_req = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    check("collide_no_ack", {31'h0, wr_ack}, 32'h0);
    check("collide_busy",   {31'h0, busy},   32'h1);
    check("collide_reg4",   r[4], 32'h0);
    repeat (9) @(posedge clk);
    check("clr10_reg9_pending", r[9], 32'hCAFEF00D);
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("clr_rst");
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    do_write(5'd2, 32'h55AA55AA, 4'hF, 32'h55AA55AA);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
